axi_wreq_chs: RTL

Write-request channel of the AXI MMU wrapper: accepts AW and W from the upstream master, bounds-checks and translates each burst against a segment (base, size), and either forwards AW plus its W beats to the memory side or sinks the burst and emits a one-cycle `drop` pulse (with AWID/AWUSER) to the write-response channel, which then returns DECERR. One burst is in flight at a time; W data is a combinational passthrough once the burst is granted.

---
 rtl/axi_wreq_chs.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/axi_wreq_chs.sv
// axi_wreq_chs: write-request channel of the MMU wrapper. Translates each AW burst by the segment base, forwards it, or sinks it.
// Latency: out_maw* valid two cycles from the AW handshake cycle (capture, then check/translate); W passthrough is zero latency.
// Backpressure: one burst in flight; out_maw* held until in_mawready; out_swready mirrors in_mwready while forwarding.
// Ports: in_saw*/out_sawready = upstream AW, in_sw*/out_swready = upstream W, out_maw*/in_mawready = memory AW,
//        out_mw*/in_mwready = memory W, in_seg_base/in_seg_size = segment, in_bfree/drop/out_awid/out_awuser = response side.
// Build option: define AXI_WREQ_SEG_CHECK_EN to enable the bounds check and the drop path; otherwise every burst is forwarded.
module axi_wreq_chs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     in_sawid,
  input  logic [ADDR_WIDTH-1:0]   in_sawaddr,
  input  logic [7:0]              in_sawlen,
  input  logic [2:0]              in_sawsize,
  input  logic [USER_WIDTH-1:0]   in_sawuser,
  input  logic                    in_sawvalid,
  output logic                    out_sawready,
  input  logic [DATA_WIDTH-1:0]   in_swdata,
  input  logic [DATA_WIDTH/8-1:0] in_swstrb,
  input  logic                    in_swlast,
  input  logic                    in_swvalid,
  output logic                    out_swready,
  output logic [ID_WIDTH-1:0]     out_mawid,
  output logic [ADDR_WIDTH-1:0]   out_mawaddr,
  output logic [7:0]              out_mawlen,
  output logic [2:0]              out_mawsize,
  output logic [USER_WIDTH-1:0]   out_mawuser,
  output logic                    out_mawvalid,
  input  logic                    in_mawready,
  output logic [DATA_WIDTH-1:0]   out_mwdata,
  output logic [DATA_WIDTH/8-1:0] out_mwstrb,
  output logic                    out_mwlast,
  output logic                    out_mwvalid,
  input  logic                    in_mwready,
  input  logic [ADDR_WIDTH-1:0]   in_seg_base,
  input  logic [ADDR_WIDTH-1:0]   in_seg_size,
  input  logic                    in_bfree,
  output logic                    drop,
  output logic [ID_WIDTH-1:0]     out_awid,
  output logic [USER_WIDTH-1:0]   out_awuser
);

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, DATA, DROP, DRESP} state_t;

  state_t                  state;
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    sawready_q;

  logic                    pass;
  logic [ADDR_WIDTH-1:0]   paddr;

  // Translation wraps modulo 2^ADDR_WIDTH.
  assign paddr = aw_addr + in_seg_base;

`ifdef AXI_WREQ_SEG_CHECK_EN
  // One extra bit so addr + bytes cannot wrap and falsely pass.
  logic [ADDR_WIDTH:0] bytes;
  logic [ADDR_WIDTH:0] span;
  assign bytes = ({{(ADDR_WIDTH-7){1'b0}}, aw_len} + {{ADDR_WIDTH{1'b0}}, 1'b1}) << aw_size;
  assign span  = {1'b0, aw_addr} + bytes;
  assign pass  = (span <= {1'b0, in_seg_size});
  assign drop  = (state == DRESP) && in_bfree;
`else
  logic unused_seg_size;
  assign unused_seg_size = ^in_seg_size;
  assign pass = 1'b1;
  assign drop = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      sawready_q   <= 1'b0;
      aw_id        <= '0;
      aw_addr      <= '0;
      aw_len       <= '0;
      aw_size      <= '0;
      aw_user      <= '0;
      out_mawid    <= '0;
      out_mawaddr  <= '0;
      out_mawlen   <= '0;
      out_mawsize  <= '0;
      out_mawuser  <= '0;
      out_mawvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Ready comes up one edge after reset release, then stays up in IDLE.
          if (!sawready_q) begin
            sawready_q <= 1'b1;
          end else if (in_sawvalid) begin
            aw_id      <= in_sawid;
            aw_addr    <= in_sawaddr;
            aw_len     <= in_sawlen;
            aw_size    <= in_sawsize;
            aw_user    <= in_sawuser;
            sawready_q <= 1'b0;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (pass) begin
            out_mawid    <= aw_id;
            out_mawaddr  <= paddr;
            out_mawlen   <= aw_len;
            out_mawsize  <= aw_size;
            out_mawuser  <= aw_user;
            out_mawvalid <= 1'b1;
            state        <= ISSUE;
          end else begin
            state <= DROP;
          end
        end
        ISSUE: begin
          if (in_mawready) begin
            out_mawvalid <= 1'b0;
            state        <= DATA;
          end
        end
        DATA: begin
          if (in_swvalid && in_mwready && in_swlast) begin
            sawready_q <= 1'b1;
            state      <= IDLE;
          end
        end
        DROP: begin
          if (in_swvalid && in_swlast) state <= DRESP;
        end
        DRESP: begin
          if (in_bfree) begin
            sawready_q <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_sawready = sawready_q;
  assign out_awid     = aw_id;
  assign out_awuser   = aw_user;

  // W path: forwarded only while DATA; sunk unconditionally in DROP.
  assign out_swready = (state == DATA) ? in_mwready : (state == DROP);
  assign out_mwvalid = (state == DATA) && in_swvalid;
  assign out_mwdata  = (state == DATA) ? in_swdata : '0;
  assign out_mwstrb  = (state == DATA) ? in_swstrb : '0;
  assign out_mwlast  = (state == DATA) && in_swlast;

endmodule
